// File: rtl/level_meter_bar.sv
// Level meter bar: log2 leading-one scan of each accepted sample, peak-hold with
// per-sample decay, and thermometer/one-hot display words behind valid/ready.
module level_meter_bar #(
   parameter int width         = 16,
   parameter int hold_updates  = 32,
   parameter int decay_updates = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         i_valid,
   output logic                         i_ready,
   input  logic [width-1:0]             i_value,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [width-1:0]             o_bar,
   output logic [width-1:0]             o_peak,
   output logic [$clog2(width+1)-1:0]   o_level
);

   localparam int LW = $clog2(width + 1);
   localparam int HW = $clog2(hold_updates + 1);
   localparam int DW = $clog2(decay_updates + 1);

   typedef enum logic [1:0] {IDLE, SCAN, PEAK, OUT} state_t;

   state_t            state_q, state_d;
   logic [width-1:0]  shift_q, shift_d;
   logic [LW-1:0]     idx_q, idx_d;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     peak_q, peak_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [DW-1:0]     decay_q, decay_d;
   logic              i_ready_q, i_ready_d;
   logic              o_valid_q, o_valid_d;
   logic [width-1:0]  o_bar_q, o_bar_d;
   logic [width-1:0]  o_peak_q, o_peak_d;
   logic [LW-1:0]     o_level_q, o_level_d;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      level_d   = level_q;
      peak_d    = peak_q;
      hold_d    = hold_q;
      decay_d   = decay_q;
      i_ready_d = i_ready_q;
      o_valid_d = o_valid_q;
      o_bar_d   = o_bar_q;
      o_peak_d  = o_peak_q;
      o_level_d = o_level_q;
      case (state_q)
         IDLE: begin
            if (i_valid && i_ready_q) begin
               shift_d   = i_value;
               idx_d     = LW'(width);
               i_ready_d = 1'b0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (shift_q[width-1] || idx_q == '0) begin
               level_d = idx_q;
               state_d = PEAK;
            end else begin
               shift_d = shift_q << 1;
               idx_d   = idx_q - LW'(1);
            end
         end
         PEAK: begin
            if (level_q >= peak_q) begin
               peak_d  = level_q;
               hold_d  = HW'(hold_updates - 1);
               decay_d = DW'(decay_updates - 1);
            end else if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end else if (decay_q != '0) begin
               decay_d = decay_q - DW'(1);
            end else begin
               peak_d  = peak_q - LW'(1);
               decay_d = DW'(decay_updates - 1);
            end
            // Bar shows this sample's level; the marker shows the held peak.
            for (int unsigned i = 0; i < width; i++) begin
               o_bar_d[i]  = (LW'(i) < level_q);
               o_peak_d[i] = (LW'(i + 1) == peak_d);
            end
            o_level_d = level_q;
            o_valid_d = 1'b1;
            state_d   = OUT;
         end
         OUT: begin
            if (o_ready) begin
               o_valid_d = 1'b0;
               i_ready_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         level_q   <= '0;
         peak_q    <= '0;
         hold_q    <= '0;
         decay_q   <= '0;
         i_ready_q <= 1'b1;
         o_valid_q <= 1'b0;
         o_bar_q   <= '0;
         o_peak_q  <= '0;
         o_level_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         level_q   <= level_d;
         peak_q    <= peak_d;
         hold_q    <= hold_d;
         decay_q   <= decay_d;
         i_ready_q <= i_ready_d;
         o_valid_q <= o_valid_d;
         o_bar_q   <= o_bar_d;
         o_peak_q  <= o_peak_d;
         o_level_q <= o_level_d;
      end
   end

   assign i_ready = i_ready_q;
   assign o_valid = o_valid_q;
   assign o_bar   = o_bar_q;
   assign o_peak  = o_peak_q;
   assign o_level = o_level_q;

endmodule
